// File: rtl/handshake_pkg.sv
// Shared helpers for the multi-channel handshake occupancy pool.
package handshake_pkg;

  // Widest channel vector the popcount helper accepts.
  localparam int unsigned MaxCh = 64;

  // Number of set bits; callers zero-extend their vector to MaxCh bits.
  function automatic int unsigned popcount(input logic [MaxCh-1:0] vec);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxCh; i++) begin
      n += 32'(vec[i]);
    end
    return n;
  endfunction

  // Parameter legality: at least one channel/slot, pool not larger than the channels can hold.
  function automatic bit params_ok(input int unsigned num_ch, input int unsigned depth,
                                   input int unsigned total_depth);
    return (num_ch >= 1) && (num_ch <= MaxCh) && (depth >= 1) && (total_depth >= 1) &&
           (total_depth <= num_ch * depth);
  endfunction

endpackage

// File: rtl/handshake_pool_allocator.sv
// Round-robin grant of the free pool slots among eligible channels.
module handshake_pool_allocator
  import handshake_pkg::*;
#(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned TotalDepth = 8,
  localparam int unsigned TotW      = $clog2(TotalDepth + 1)
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             clear,
  input  logic [NumCh-1:0] eligible,
  input  logic [TotW-1:0]  free,
  output logic [NumCh-1:0] grant
);

  localparam int unsigned PtrW = (NumCh > 1) ? $clog2(NumCh) : 1;

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] last;
  logic [TotW-1:0] given;
  logic            limited;

  // Grant everyone eligible unless oversubscribed; then the first `free` from rr_ptr, wrapping.
  always_comb begin
    grant   = '0;
    given   = '0;
    last    = rr_ptr_q;
    limited = popcount(MaxCh'(eligible)) > 32'(free);
    if (!limited) begin
      grant = eligible;
    end else begin
      // Pass 0 scans rr_ptr..NumCh-1, pass 1 wraps over 0..rr_ptr-1.
      for (int unsigned pass = 0; pass < 2; pass++) begin
        for (int unsigned c = 0; c < NumCh; c++) begin
          if (((pass == 0) == (c >= 32'(rr_ptr_q))) && eligible[c] && (given < free)) begin
            grant[c] = 1'b1;
            given    = given + TotW'(1);
            last     = PtrW'(c);
          end
        end
      end
    end
  end

  // Pointer advances past the last grant of a limited cycle, whether or not it handshook.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (clear) begin
      rr_ptr_d = '0;
    end else if (limited && (free != '0)) begin
      rr_ptr_d = (32'(last) == NumCh - 1) ? '0 : last + PtrW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/handshake_storage_pool.sv
// Token occupancy tracker for NumCh valid/ready channels sharing a TotalDepth pool.
module handshake_storage_pool
  import handshake_pkg::*;
#(
  parameter int unsigned NumCh      = 4,
  parameter int unsigned Depth      = 4,
  parameter int unsigned TotalDepth = 8,
  localparam int unsigned CntW      = $clog2(Depth + 1),
  localparam int unsigned TotW      = $clog2(TotalDepth + 1)
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic                       clear_i,
  input  logic [NumCh-1:0]           in_valid_i,
  output logic [NumCh-1:0]           in_ready_o,
  output logic [NumCh-1:0]           out_valid_o,
  input  logic [NumCh-1:0]           out_ready_i,
  output logic [NumCh-1:0][CntW-1:0] cnt_o,
  output logic [TotW-1:0]            total_o
);

  if (!params_ok(NumCh, Depth, TotalDepth)) begin : gen_bad_params
    $error("handshake_storage_pool: illegal NumCh/Depth/TotalDepth combination");
  end

  logic [NumCh-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [TotW-1:0]            total_q, total_d;
  logic [TotW:0]              total_ext;
  logic [TotW-1:0]            free;
  logic [NumCh-1:0]           eligible, in_hs, out_hs;
  logic [31:0]                cnt_sum;

  // Eligibility and free slots come from registered state only.
  always_comb begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      eligible[c]    = cnt_q[c] != CntW'(Depth);
      out_valid_o[c] = cnt_q[c] != '0;
    end
    free = TotW'(TotalDepth) - total_q;
  end

  handshake_pool_allocator #(
    .NumCh      (NumCh),
    .TotalDepth (TotalDepth)
  ) u_allocator (
    .clk_i    (clk_i),
    .arst_ni  (arst_ni),
    .clear    (clear_i),
    .eligible (eligible),
    .free     (free),
    .grant    (in_ready_o)
  );

  assign in_hs  = in_valid_i & in_ready_o;
  assign out_hs = out_valid_o & out_ready_i;

  // Per-channel and total next counts; clear wins over any handshake this cycle.
  always_comb begin
    total_ext = {1'b0, total_q} + (TotW + 1)'(popcount(MaxCh'(in_hs)))
                - (TotW + 1)'(popcount(MaxCh'(out_hs)));
    total_d   = clear_i ? '0 : total_ext[TotW-1:0];
    cnt_sum   = '0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      cnt_d[c] = cnt_q[c];
      if (clear_i) begin
        cnt_d[c] = '0;
      end else if (in_hs[c] && !out_hs[c]) begin
        cnt_d[c] = cnt_q[c] + CntW'(1);
      end else if (out_hs[c] && !in_hs[c]) begin
        cnt_d[c] = cnt_q[c] - CntW'(1);
      end
      cnt_sum += 32'(cnt_q[c]);
    end
  end

  // Occupancy registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      total_q <= total_d;
    end
  end

  // Total must track the channel sum and never leave 0..TotalDepth.
  always_ff @(posedge clk_i) begin
    if (arst_ni) begin
      assert (32'(total_q) == cnt_sum);
      assert (total_q <= TotW'(TotalDepth));
      assert (clear_i || (!total_ext[TotW] && (total_ext <= (TotW + 1)'(TotalDepth))));
    end
  end

  assign cnt_o   = cnt_q;
  assign total_o = total_q;

endmodule

// File: doc/handshake_storage_pool.md
Name: handshake_storage_pool

Overview:
- Multi-channel successor to the single-channel handshake occupancy counter.
- Tracks buffered tokens (no data) for NumCh independent valid/ready channels. Each channel has its own Depth limit, and all channels share a TotalDepth capacity pool.
- Allocates the pool fairly, round-robin, when it is oversubscribed. Used as the credit/occupancy tracker beside per-channel data storage in multi-queue buffers.

Parameters:
- NumCh, 4, number of channels (>=1).
- Depth, 4, max tokens held per channel (>=1).
- TotalDepth, 8, max tokens held across all channels; 1 <= TotalDepth <= NumCh*Depth.
- CntW, $clog2(Depth+1), per-channel count width (derived, not overridden).
- TotW, $clog2(TotalDepth+1), total count width (derived, not overridden).

Ports:
- clk_i  input  1  clock.
- arst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous flush of all counts.
- in_valid_i  input  [NumCh-1:0]  per-channel producer valid.
- in_ready_o  output  [NumCh-1:0]  per-channel accept.
- out_valid_o  output  [NumCh-1:0]  per-channel token available.
- out_ready_i  input  [NumCh-1:0]  per-channel consumer ready.
- cnt_o  output  [NumCh-1:0][CntW-1:0]  per-channel occupancy.
- total_o  output  [TotW-1:0]  sum of all cnt_o.

Behaviour:
- Reset (arst_ni low, asynchronous):
  - cnt_o=0 and total_o=0.
  - rr_ptr=0.
  - out_valid_o=0.
  - in_ready_o follows the allocation rule below, evaluated on reset state.
- out_valid_o[c] = (cnt_o[c] != 0). Purely registered-state driven.
- Eligibility: eligible[c] = (cnt_o[c] != Depth). free = TotalDepth - total_o.
- in_ready_o is a function of registered state only. It must never depend on in_valid_i or out_ready_i, and no combinational path from any input to any output is allowed.
- Not pool-limited (popcount(eligible) <= free): in_ready_o = eligible.
- Pool-limited (popcount(eligible) > free):
  - Scan channels starting at rr_ptr, wrapping modulo NumCh.
  - Assert in_ready_o for the first `free` eligible channels found; all other channels get 0.
  - free=0 gives in_ready_o=0.
- rr_ptr update:
  - In a pool-limited cycle with free>0: rr_ptr <= (index of last granted channel + 1) mod NumCh. This applies whether or not the grants handshook.
  - Otherwise rr_ptr holds.
- Handshakes: in_hs[c] = in_valid_i[c] & in_ready_o[c]; out_hs[c] = out_valid_o[c] & out_ready_i[c].
- Per-channel next count:
  - in_hs only: +1.
  - out_hs only: -1.
  - both or neither: hold.
- total_o next = total_o + popcount(in_hs) - popcount(out_hs).
  - Compute at TotW+1 bits; the result must stay within 0..TotalDepth by construction.
  - Simulation assertions check total_o == sum(cnt_o) and total_o <= TotalDepth.
- Slots freed by out_hs become grantable only in the next cycle. There is no same-cycle reuse.
- clear_i=1:
  - All cnt_o <= 0, total_o <= 0, rr_ptr <= 0 next cycle.
  - Overrides any in_hs/out_hs that cycle. Handshakes may still complete at the ports; an upstream data store must discard them too.
- Reset mid-operation: all state returns to reset values immediately; no pending handshake is retained.
- NumCh=1 must degenerate to the single-channel behaviour with capacity min(Depth, TotalDepth).

Decomposition:
- Shared package (handshake_pkg): helper function for popcount, and the parameter legality checks as elaboration-time assertions.
- Sub-module handshake_pool_allocator:
  - Contains the rr_ptr register plus the combinational wrapped-priority grant of `free` slots among eligible channels.
  - Inputs: eligible, free, clear.
  - Output: grant vector (becomes in_ready_o).
- The top level holds the counters, handshake logic and total accumulator.

Test Plan (NumCh=4, Depth=4, TotalDepth=8):
- Reset, idle: after arst_ni release -> cnt_o all 0, total_o=0, out_valid_o=4'b0000, in_ready_o=4'b1111.
- Single-channel fill: in_valid_i=4'b0001 for 6 cycles, out_ready_i=0 -> cnt_o[0] reaches 4 after 4 cycles, then in_ready_o[0]=0; total_o=4; cnt_o[0] stays 4.
- Pool exhaustion: in_valid_i=4'b1111, out_ready_i=0 from reset -> after 2 cycles cnt_o={2,2,2,2}, total_o=8, in_ready_o=4'b0000 thereafter.
- Fair allocation: from the full state, pop one token each from ch0 and ch1 in one cycle (total_o=6, free=2, 4 eligible, rr_ptr=0), all in_valid_i=1:
  - Next cycle: in_ready_o=4'b0011, rr_ptr becomes 2.
  - After one cycle in which ch2 and ch3 each pop one token, in_ready_o=4'b1100.
  - Over repeated rounds, every channel is granted within 2 limited cycles.
- Simultaneous in/out: ch1 cnt=2, in_valid_i[1]=1, out_ready_i[1]=1 for 3 cycles -> cnt_o[1] stays 2, total_o unchanged, in_hs and out_hs both observed each cycle.
- Clear and async reset mid-traffic:
  - clear_i=1 for one cycle during random traffic -> next cycle all counts 0 and out_valid_o=0.
  - arst_ni pulsed low between clock edges with total_o=5 -> outputs zero immediately, before the next clock edge.
